// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad scanner with single-key debounce. Rotates a
//            one-hot column drive, samples synchronized rows, debounces one
//            press, and presents the accepted key as a one-hot {rows, cols}
//            pair for the downstream keypad decoder.
// Ports    : clk       - system clock
//            reset     - asynchronous active-high reset
//            rows_in   - raw keypad rows (active-high, async to clk)
//            cols_out  - one-hot active-high column drive
//            key_rows  - one-hot row of last accepted key
//            key_cols  - one-hot column of last accepted key
//            key_valid - high while the accepted key is held
//            key_new   - one-cycle pulse on each newly accepted press
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_in,
    output logic [3:0] cols_out,
    output logic [3:0] key_rows,
    output logic [3:0] key_cols,
    output logic       key_valid,
    output logic       key_new
);

    // One counter serves both column dwell and debounce, so it is sized for
    // whichever of the two terminal counts is larger.
    localparam int c_CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_sync1;
    logic [3:0]         r_rows_s;
    logic [3:0]         r_cap_row;
    logic [3:0]         r_cap_col;
    logic [3:0]         w_cap_row_nxt;
    logic [3:0]         w_cap_col_nxt;
    logic [3:0]         w_cols_nxt;
    logic [3:0]         w_key_rows_nxt;
    logic [3:0]         w_key_cols_nxt;
    logic               w_key_valid_nxt;
    logic               w_key_new_nxt;
    logic [3:0]         w_cols_rot;
    logic               w_row_onehot;
    logic               w_cap_row_high;

    assign w_cols_rot     = {cols_out[2:0], cols_out[3]};
    // Exactly one row set: nonzero and clearing the lowest set bit leaves zero.
    assign w_row_onehot   = (r_rows_s != 4'b0000) &&
                            ((r_rows_s & (r_rows_s - 4'd1)) == 4'b0000);
    assign w_cap_row_high = ((r_rows_s & r_cap_row) != 4'b0000);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 4'b0000;
            r_rows_s  <= 4'b0000;
            r_state   <= ST_SCAN;
            r_cnt     <= '0;
            r_cap_row <= 4'b0000;
            r_cap_col <= 4'b0000;
            cols_out  <= 4'b0001;
            key_rows  <= 4'b0000;
            key_cols  <= 4'b0000;
            key_valid <= 1'b0;
            key_new   <= 1'b0;
        end else begin
            r_sync1   <= rows_in;
            r_rows_s  <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cap_row <= w_cap_row_nxt;
            r_cap_col <= w_cap_col_nxt;
            cols_out  <= w_cols_nxt;
            key_rows  <= w_key_rows_nxt;
            key_cols  <= w_key_cols_nxt;
            key_valid <= w_key_valid_nxt;
            key_new   <= w_key_new_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cap_row_nxt   = r_cap_row;
        w_cap_col_nxt   = r_cap_col;
        w_cols_nxt      = cols_out;
        w_key_rows_nxt  = key_rows;
        w_key_cols_nxt  = key_cols;
        w_key_valid_nxt = key_valid;
        w_key_new_nxt   = 1'b0;

        case (r_state)
            ST_SCAN: begin
                // Rows are only trusted on the last dwell cycle, when the
                // synchronizer has had time to reflect the current column.
                if (r_cnt == c_DWELL_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_row_onehot) begin
                        w_cap_row_nxt = r_rows_s;
                        w_cap_col_nxt = cols_out;
                        w_state_nxt   = ST_DB_PRESS;
                    end else begin
                        w_cols_nxt = w_cols_rot;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            ST_DB_PRESS: begin
                // Mismatch wins over terminal count: a bounce on the final
                // cycle still aborts the press.
                if (r_rows_s != r_cap_row) begin
                    w_state_nxt = ST_SCAN;
                    w_cols_nxt  = w_cols_rot;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DB_LAST) begin
                    w_state_nxt     = ST_HELD;
                    w_cnt_nxt       = '0;
                    w_key_rows_nxt  = r_cap_row;
                    w_key_cols_nxt  = r_cap_col;
                    w_key_valid_nxt = 1'b1;
                    w_key_new_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            ST_HELD: begin
                // Only the captured row matters; other rows are ignored.
                if (!w_cap_row_high) begin
                    w_state_nxt = ST_DB_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end

            ST_DB_RELEASE: begin
                if (w_cap_row_high) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DB_LAST) begin
                    w_state_nxt     = ST_SCAN;
                    w_cnt_nxt       = '0;
                    w_key_valid_nxt = 1'b0;
                    w_cols_nxt      = w_cols_rot;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_SCAN;
                w_cnt_nxt   = '0;
                w_cols_nxt  = 4'b0001;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed self-checking bench for keypad_scanner. A keypad model
//            closes row/column contacts from a pressed-key matrix; each step
//            compares DUT outputs against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows_in;
    logic [3:0] cols_out;
    logic [3:0] key_rows;
    logic [3:0] key_cols;
    logic       key_valid;
    logic       key_new;

    // pressed[col*4 + row] = switch closed at (row, col)
    logic [15:0] pressed;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Keypad: a driven column pulls up the rows of its closed switches.
    always_comb begin
        rows_in = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (cols_out[c]) rows_in = rows_in | pressed[c*4 +: 4];
        end
    end

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows_in   (rows_in),
        .cols_out  (cols_out),
        .key_rows  (key_rows),
        .key_cols  (key_cols),
        .key_valid (key_valid),
        .key_new   (key_new)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        pressed = 16'h0000;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cols",  cols_out, 4'b0001);
        check("rst_rows",  key_rows, 4'b0000);
        check("rst_kcols", key_cols, 4'b0000);
        check("rst_valid", {3'b000, key_valid}, 4'd0);
        check("rst_new",   {3'b000, key_new},   4'd0);
        reset = 1'b0;

        // Idle scan: 4 cycles per column, full period 16
        for (int i = 0; i < 32; i++) begin
            check("idle_cols", cols_out, 4'b0001 << ((i / 4) % 4));
            check("idle_new",  {3'b000, key_new}, 4'd0);
            @(negedge clk);
        end

        // Clean press at (row 0010, col 0100): captured at t=12, accepted t=20
        pressed[2*4 + 1] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            check("clean_new",  {3'b000, key_new}, (t == 20) ? 4'd1 : 4'd0);
            check("clean_cols", cols_out, (t < 8) ? (4'b0001 << (t / 4)) : 4'b0100);
            if (t == 20) begin
                check("clean_krows", key_rows, 4'b0010);
                check("clean_kcols", key_cols, 4'b0100);
                check("clean_valid", {3'b000, key_valid}, 4'd1);
            end
        end

        // Clean release: DB_RELEASE entered at u=3, key_valid falls at u=11
        pressed = 16'h0000;
        for (int u = 1; u <= 11; u++) begin
            @(negedge clk);
            check("rel1_valid", {3'b000, key_valid}, (u < 11) ? 4'd1 : 4'd0);
            check("rel1_new",   {3'b000, key_new}, 4'd0);
        end
        check("rel1_cols",  cols_out, 4'b1000);
        check("rel1_krows", key_rows, 4'b0010);
        check("rel1_kcols", key_cols, 4'b0100);

        // Bouncy press at (row 1000, col 1000): on 3 / off 3 until v=18, then
        // stable. First capture at v=4 aborts at v=6; recapture v=22, accept v=30.
        pressed[15] = 1'b1;
        for (int v = 1; v <= 40; v++) begin
            @(negedge clk);
            pressed[15] = (((v / 3) % 2) == 0) || (v >= 18);
            check("bounce_new", {3'b000, key_new}, (v == 30) ? 4'd1 : 4'd0);
            if (v == 4 || v == 5) check("bounce_hold_cols", cols_out, 4'b1000);
            if (v == 6)           check("bounce_abort_cols", cols_out, 4'b0001);
            if (v == 30) begin
                check("bounce_krows", key_rows, 4'b1000);
                check("bounce_kcols", key_cols, 4'b1000);
                check("bounce_valid", {3'b000, key_valid}, 4'd1);
            end
        end

        pressed = 16'h0000;
        for (int w = 1; w <= 11; w++) begin
            @(negedge clk);
            check("rel2_valid", {3'b000, key_valid}, (w < 11) ? 4'd1 : 4'd0);
        end
        check("rel2_cols", cols_out, 4'b0001);

        // Key (0001,0001) accepted at x=12; second key (0100,0001) at x=20
        pressed[0] = 1'b1;
        for (int x = 1; x <= 40; x++) begin
            @(negedge clk);
            check("second_new", {3'b000, key_new}, (x == 12) ? 4'd1 : 4'd0);
            if (x == 12) begin
                check("second_krows0", key_rows, 4'b0001);
                check("second_kcols0", key_cols, 4'b0001);
            end
            if (x == 20) pressed[2] = 1'b1;
        end
        check("second_krows", key_rows, 4'b0001);
        check("second_kcols", key_cols, 4'b0001);
        check("second_valid", {3'b000, key_valid}, 4'd1);
        check("second_cols",  cols_out, 4'b0001);

        // Release with bounce: low, high at y=3..4, then low; valid falls y=16
        pressed = 16'h0000;
        for (int y = 1; y <= 16; y++) begin
            @(negedge clk);
            if (y == 3) pressed[0] = 1'b1;
            if (y == 5) pressed[0] = 1'b0;
            check("relb_valid", {3'b000, key_valid}, (y < 16) ? 4'd1 : 4'd0);
            check("relb_new",   {3'b000, key_new}, 4'd0);
        end
        check("relb_cols",  cols_out, 4'b0010);
        check("relb_krows", key_rows, 4'b0001);
        check("relb_kcols", key_cols, 4'b0001);

        // Press (0100,0010), accepted at z=12, then reset mid-hold
        pressed[1*4 + 2] = 1'b1;
        for (int z = 1; z <= 20; z++) begin
            @(negedge clk);
            check("pre_rst_new", {3'b000, key_new}, (z == 12) ? 4'd1 : 4'd0);
        end
        check("pre_rst_valid", {3'b000, key_valid}, 4'd1);
        check("pre_rst_cols",  cols_out, 4'b0010);

        #2 reset = 1'b1;
        #1;
        check("midrst_cols",  cols_out, 4'b0001);
        check("midrst_valid", {3'b000, key_valid}, 4'd0);
        check("midrst_krows", key_rows, 4'b0000);
        check("midrst_kcols", key_cols, 4'b0000);
        check("midrst_new",   {3'b000, key_new}, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        // Still-held key re-detected in column 0010: captured a=8, accepted a=16
        for (int a = 1; a <= 16; a++) begin
            @(negedge clk);
            check("post_rst_new", {3'b000, key_new}, (a == 16) ? 4'd1 : 4'd0);
        end
        check("post_rst_krows", key_rows, 4'b0100);
        check("post_rst_kcols", key_cols, 4'b0010);
        check("post_rst_valid", {3'b000, key_valid}, 4'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and drives the key-decoder/seven-segment path. The block rotates a one-hot column drive and samples the synchronized row inputs. It debounces a single key press and presents the accepted key as a one-hot `{rows, cols}` pair to the existing keypad decoder. A one-cycle pulse marks each new accepted press; held keys and other keys pressed during a hold are ignored.

## Interface
Parameters:
- `SCAN_DIV`, 4: clock cycles each column is driven during scanning; must be ≥ 4 so the 2-flop synchronizer settles.
- `DEBOUNCE_CYCLES`, 8: consecutive stable cycles required to accept a press or a release; ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `rows_in`  in  4  raw keypad rows; active-high, pulled down; asynchronous to `clk`.
- `cols_out`  out  4  one-hot active-high column drive.
- `key_rows`  out  4  one-hot row of the last accepted key; feeds decoder `rows`.
- `key_cols`  out  4  one-hot column of the last accepted key; feeds decoder `cols`.
- `key_valid`  out  1  high while the accepted key is held, including through release debounce.
- `key_new`  out  1  one-cycle pulse on acceptance of a new press.

## Operation
- **Synchronizer:** `rows_in` passes through 2 flops to give `rows_s`. All decisions use `rows_s` only.
- **States:** SCAN, DB_PRESS, HELD, DB_RELEASE. A single counter `cnt` serves both the column dwell and debounce.
- **SCAN:**
  - `cols_out` rotates 0001→0010→0100→1000→0001, advancing every `SCAN_DIV` cycles.
  - `rows_s` is sampled on the last dwell cycle only.
  - If exactly one bit is set: capture `cap_row = rows_s`, `cap_col = cols_out`; freeze `cols_out`; clear `cnt`; go to DB_PRESS.
  - If zero or ≥2 bits are set: keep scanning. Multi-key presses within a column are rejected.
- **DB_PRESS:**
  - `cols_out` is held.
  - If `rows_s == cap_row`, `cnt++`. Otherwise go to SCAN and advance to the next column with a fresh dwell.
  - When `cnt == DEBOUNCE_CYCLES-1` and the row still matches, go to HELD. On that same edge: `key_rows <= cap_row`, `key_cols <= cap_col`, `key_valid <= 1`, `key_new <= 1` (cleared the following cycle).
- **HELD:**
  - `cols_out` is held.
  - Other rows going high are ignored.
  - When `rows_s & cap_row == 0`: clear `cnt`, go to DB_RELEASE.
- **DB_RELEASE:**
  - If the captured row stays low, `cnt++`. If it goes high again, return to HELD with no new `key_new`.
  - When `cnt == DEBOUNCE_CYCLES-1`, go to SCAN. On that edge `key_valid <= 0` and `cols_out` advances to the next column.
- `key_rows`/`key_cols` retain the last accepted key after release so the display keeps the value. They change only on acceptance.
- **Reset values** (asynchronous, any state): state=SCAN, `cols_out=0001`, `cnt=0`, sync flops 0, `key_rows=0000`, `key_cols=0000`, `key_valid=0`, `key_new=0`.

## Timing
- All outputs are registered.
- Input to `rows_s` latency is 2 cycles.
- **Press latency:** from the rising edge of `rows_in` (column already driven) to `key_new` is at most 2 sync cycles + remaining dwell (≤ `SCAN_DIV`) + `DEBOUNCE_CYCLES` cycles.
  - `key_new` is high exactly `DEBOUNCE_CYCLES` cycles after entering DB_PRESS.
- **Release latency:** `key_valid` falls `DEBOUNCE_CYCLES` cycles after entering DB_RELEASE.
- **Full scan period:** `4*SCAN_DIV` cycles when idle.
- **Simultaneous events:** in DB_PRESS the mismatch check takes priority over the count reaching its terminal value. A bounce on the final cycle aborts the press.
- **Reset mid-hold:** outputs clear immediately; no `key_new` is issued for the still-held key until it is re-detected via SCAN and a full debounce completes.
- `key_new` never asserts twice without an intervening return to SCAN.

## Test plan
All scenarios use `SCAN_DIV=4`, `DEBOUNCE_CYCLES=8`.
- **Reset:** assert `reset` mid-HELD → same cycle `cols_out=0001`, `key_valid=0`, `key_rows/key_cols=0000`, `key_new=0`.
- **Idle scan:** `rows_in=0000` for 32 cycles → `cols_out` sequence 0001,0010,0100,1000 with 4 cycles each, repeating; `key_new` never high.
- **Clean press:** `rows_in=0010` only while `cols_out=0100`, held for 40 cycles → single `key_new` pulse, `key_rows=0010`, `key_cols=0100`, `key_valid=1`; `cols_out` frozen at 0100 while held.
- **Bouncy press:** row toggles every 3 cycles for 20 cycles, then stable → no `key_new` during bounce; exactly one `key_new` 8 cycles after stable detection.
- **Second key while held:** hold key (0001,0001), then also press (0100,0001) → no additional `key_new`; `key_rows` stays 0001.
- **Release with bounce:** release, re-high 3 cycles later, then low for 8+ cycles → `key_valid` stays 1 through the bounce, then falls after 8 stable-low cycles; `key_rows/key_cols` retain 0001/0001; scanning resumes at `cols_out=0010`.
